// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the elastic FP add/sub pipeline.
// Op encoding, DW rounding modes, status bit positions, canonical QNaN.
package fp_addsub_pkg;

  typedef enum logic {
    FP_ADD = 1'b0,
    FP_SUB = 1'b1
  } fp_op_e;

  localparam logic [2:0] RND_RNE = 3'b000;
  localparam logic [2:0] RND_RZ  = 3'b001;
  localparam logic [2:0] RND_RUP = 3'b010;
  localparam logic [2:0] RND_RDN = 3'b011;
  localparam logic [2:0] RND_RNA = 3'b100;

  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_INVALID = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/fp_pipe_stage.sv
// Elastic register slice: loads when empty or when its contents leave.
// Ports: clk, rst_n, in_val_i/in_rdy_o/in_data_i, out_val_o/out_rdy_i/out_data_o.
module fp_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_val_i,
  output logic          in_rdy_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_val_o,
  input  logic          out_rdy_i,
  output logic [DW-1:0] out_data_o
);

  logic          val_q;
  logic          val_d;
  logic [DW-1:0] data_q;

  assign in_rdy_o = !val_q || out_rdy_i;
  // Loading an empty upstream slot clears val: bubbles collapse.
  assign val_d = in_rdy_o ? in_val_i : val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= 1'b0;
    else        val_q <= val_d;
  end

  always_ff @(posedge clk) begin
    if (in_rdy_o && in_val_i) data_q <= in_data_i;
  end

  assign out_val_o  = val_q;
  assign out_data_o = data_q;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Elastic IEEE-style FP add/sub, NSTAGES register stages, valid/ready.
// Ports: clk, reset(async low), in_val/in_rdy/in_op/in_rnd/in0/in1,
//   out_val/out_rdy/out/out_status; with FP_ADDSUB_PIPE_STICKY_FLAGS_EN
//   also flags_clr and sticky flags[4:0] = status[5:1].
module fp_addsub_pipe
  import fp_addsub_pkg::*;
#(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 1,
  parameter int NSTAGES         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic                           in_op,
  input  logic [2:0]                     in_rnd,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in0,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in1,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   out,
  output logic [7:0]                     out_status
`ifdef FP_ADDSUB_PIPE_STICKY_FLAGS_EN
  ,
  input  logic                           flags_clr,
  output logic [4:0]                     flags
`endif
);

  localparam int W    = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int M    = SIG_WIDTH + 1;
  localparam int X    = M + 3;
  localparam int EMAX = (1 << EXP_WIDTH) - 1;
  localparam int DW   = W + 8;

  typedef struct packed {
    logic [W-1:0] z;
    logic [7:0]   st;
  } res_t;

  // Combinational add/sub with guard/round/sticky, DW-style status.
  function automatic res_t fp_add(
    input logic [W-1:0] a_in,
    input logic [W-1:0] b_in,
    input fp_op_e       op,
    input logic [2:0]   rnd
  );
    logic sa, sb, sz, eff_sub;
    logic a_nan, b_nan, a_inf, b_inf;
    logic g, stk, inx, inc, ovf_inf;
    logic [W-2:0] maga, magb, tmp;
    logic [M-1:0] ma, mb;
    logic [X-1:0] xa, xb;
    logic [2*X-1:0] wide;
    logic [X:0] s;
    logic [M:0] mr;
    logic [SIG_WIDTH-1:0] frac;
    int ea, eb, d, ex, lz, sh, ef;
    res_t r;
    r = '0;
    sa = a_in[W-1];
    sb = b_in[W-1] ^ (op == FP_SUB);
    maga = a_in[W-2:0];
    magb = b_in[W-2:0];
    if (IEEE_COMPLIANCE == 0) begin
      if (maga[W-2:SIG_WIDTH] == '0) maga = '0;
      if (magb[W-2:SIG_WIDTH] == '0) magb = '0;
    end
    a_nan = (&maga[W-2:SIG_WIDTH]) && (|maga[SIG_WIDTH-1:0]);
    a_inf = (&maga[W-2:SIG_WIDTH]) && !(|maga[SIG_WIDTH-1:0]);
    b_nan = (&magb[W-2:SIG_WIDTH]) && (|magb[SIG_WIDTH-1:0]);
    b_inf = (&magb[W-2:SIG_WIDTH]) && !(|magb[SIG_WIDTH-1:0]);
    eff_sub = sa ^ sb;
    sz = sa;
    // Larger magnitude first so the subtraction never goes negative.
    if (magb > maga) begin
      tmp  = maga;
      maga = magb;
      magb = tmp;
      sz   = sb;
    end
    ea = {{(32-EXP_WIDTH){1'b0}}, maga[W-2:SIG_WIDTH]};
    eb = {{(32-EXP_WIDTH){1'b0}}, magb[W-2:SIG_WIDTH]};
    ma = {(ea != 0), maga[SIG_WIDTH-1:0]};
    mb = {(eb != 0), magb[SIG_WIDTH-1:0]};
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    d = ea - eb;
    if (d > X) d = X;
    xa = {ma, 3'b000};
    wide = {mb, 3'b000, {X{1'b0}}} >> d;
    xb = wide[2*X-1:X];
    xb[0] = xb[0] | (|wide[X-1:0]);
    if (eff_sub) s = {1'b0, xa} - {1'b0, xb};
    else         s = {1'b0, xa} + {1'b0, xb};
    ex = ea;
    lz = 0;
    sh = 0;
    if (s[X]) begin
      s  = {1'b0, s[X:2], s[1] | s[0]};
      ex = ex + 1;
    end else begin
      lz = X;
      for (int i = 0; i < X; i++) begin
        if (s[i]) lz = X - 1 - i;
      end
      // Stop normalising at the minimum exponent: result goes subnormal.
      sh = (lz < ex - 1) ? lz : ex - 1;
      s  = s << sh;
      ex = ex - sh;
    end
    if (s == '0) sz = eff_sub ? (rnd == RND_RDN) : sa;
    mr  = {1'b0, s[X-1:3]};
    g   = s[2];
    stk = s[1] | s[0];
    inx = g | stk;
    unique case (rnd)
      RND_RNE: inc = g & (stk | mr[0]);
      RND_RZ:  inc = 1'b0;
      RND_RUP: inc = inx & !sz;
      RND_RDN: inc = inx & sz;
      RND_RNA: inc = g;
      default: inc = inx;
    endcase
    mr = mr + {{M{1'b0}}, inc};
    // A carry out of rounding, or a subnormal rounding up to the hidden bit,
    // both bump the exponent field naturally.
    ef   = mr[M] ? ex + 1 : (mr[M-1] ? ex : 0);
    frac = mr[M] ? mr[SIG_WIDTH:1] : mr[SIG_WIDTH-1:0];
    if (IEEE_COMPLIANCE == 0 && ef == 0) frac = '0;
    unique case (rnd)
      RND_RZ:  ovf_inf = 1'b0;
      RND_RUP: ovf_inf = !sz;
      RND_RDN: ovf_inf = sz;
      default: ovf_inf = 1'b1;
    endcase
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      r.z = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
      r.st[STAT_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      r.z = {a_inf ? sa : sb, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      r.st[STAT_INF] = 1'b1;
    end else if (ef >= EMAX) begin
      r.z = ovf_inf ?
        {sz, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}} :
        {sz, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
      r.st[STAT_INF]     = ovf_inf;
      r.st[STAT_HUGE]    = 1'b1;
      r.st[STAT_INEXACT] = 1'b1;
    end else begin
      r.z = {sz, ef[EXP_WIDTH-1:0], frac};
      r.st[STAT_ZERO]    = (ef == 0) && (frac == '0);
      r.st[STAT_TINY]    = (ef == 0) && (inx || (frac != '0));
      r.st[STAT_INEXACT] = inx;
    end
    return r;
  endfunction

  logic          stg_val [NSTAGES];
  logic          stg_rdy [NSTAGES+1];
  logic [DW-1:0] stg_dat [NSTAGES];

  logic         v0_q;
  logic         v0_d;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  fp_op_e       op_q;
  logic [2:0]   rnd_q;
  res_t         res;

  // stg_rdy[k]: stage k may load; stg_rdy[NSTAGES] is the consumer.
  assign stg_rdy[NSTAGES] = out_rdy;
  assign stg_rdy[0]       = !v0_q || stg_rdy[1];
  assign in_rdy           = stg_rdy[0];
  assign v0_d             = in_rdy ? in_val : v0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v0_q <= 1'b0;
    else        v0_q <= v0_d;
  end

  always_ff @(posedge clk) begin
    if (in_val && in_rdy) begin
      a_q   <= in0;
      b_q   <= in1;
      op_q  <= fp_op_e'(in_op);
      rnd_q <= in_rnd;
    end
  end

  always_comb res = fp_add(a_q, b_q, op_q, rnd_q);

  assign stg_val[0] = v0_q;
  assign stg_dat[0] = {res.z, res.st};

  for (genvar k = 1; k < NSTAGES; k++) begin : g_stage
    fp_pipe_stage #(.DW(DW)) u_stage (
      .clk        (clk),
      .rst_n      (reset),
      .in_val_i   (stg_val[k-1]),
      .in_rdy_o   (stg_rdy[k]),
      .in_data_i  (stg_dat[k-1]),
      .out_val_o  (stg_val[k]),
      .out_rdy_i  (stg_rdy[k+1]),
      .out_data_o (stg_dat[k])
    );
  end

  assign out_val    = stg_val[NSTAGES-1];
  assign out        = out_val ? stg_dat[NSTAGES-1][DW-1:8] : '0;
  assign out_status = out_val ? stg_dat[NSTAGES-1][7:0] : '0;

`ifdef FP_ADDSUB_PIPE_STICKY_FLAGS_EN
  logic [4:0] flags_q;
  logic [4:0] flags_d;

  // A fire in the clearing cycle still lands its bits.
  always_comb begin
    flags_d = flags_clr ? 5'b0 : flags_q;
    if (out_val && out_rdy) flags_d = flags_d | out_status[5:1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 5'b0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, elastic floating-point add/subtract unit built around the DesignWare DW_fp_addsub core.
- Generalises the fixed-latency 2-stage FP adder: configurable format and pipeline depth, runtime add/sub and rounding mode, exception status, and valid/ready backpressure with bubble collapsing.
- Sits between an issue queue and a writeback arbiter in the FP datapath.

Parameters:
- SIG_WIDTH, 23, significand bits (excluding hidden bit).
- EXP_WIDTH, 8, exponent bits.
- IEEE_COMPLIANCE, 1, passed to the DW core (1 = denormals/NaN per IEEE 754).
- NSTAGES, 2, total register stages (input stage plus NSTAGES-1 retiming stages); legal range 1..8.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_val  in  1  input operation valid.
- in_rdy  out  1  unit can accept an operation this cycle.
- in_op  in  1  0 = a+b, 1 = a-b.
- in_rnd  in  3  DW rounding mode (000 = RNE).
- in0  in  W  operand a; W = 1+EXP_WIDTH+SIG_WIDTH.
- in1  in  W  operand b.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts the result.
- out  out  W  result; forced to 0 when out_val=0.
- out_status  out  8  DW status of the result; forced to 0 when out_val=0.

Behaviour:
- Transfer rules: input fires when in_val && in_rdy; output fires when out_val && out_rdy.
- Stage 0 registers operands, op and rnd. Combinational DW_fp_addsub sits between stage 0 and stage 1. With NSTAGES=1, the core output drives out directly from stage 0.
- Stages 1..NSTAGES-1 hold {val, result, status}.
- Per-stage advance: stage k loads from k-1 when stage k is empty, or when stage k's own contents move on this cycle (k+1 loads, or k is last and out_rdy=1).
- Bubbles collapse. A stage that does not load holds its data; a stage whose data leaves without a new load clears val.
- in_rdy = stage-0 empty || stage 0 advances this cycle. in_rdy is combinational from out_rdy and the val bits. There is no in_val -> in_rdy path.
- Latency: NSTAGES cycles from input fire to out_val, with out_rdy held 1. Throughput is 1/cycle.
- Full pipeline with out_rdy=0: in_rdy=0 and all contents are held bit-exact.
- Simultaneous output fire and input fire on a full pipe: both occur, and occupancy is unchanged.
- Reset (reset=0, any time including mid-operation): all val bits clear to 0 immediately. out_val=0, out=0, out_status=0, in_rdy=1 after reset deasserts. Data registers are not reset. In-flight operations are discarded.
- Status bits: 0 zero, 1 infinity, 2 invalid, 3 tiny, 4 huge, 5 inexact; bits 7:6 = 0.
- Ordering: results emerge strictly in input order; operations are never dropped or duplicated.

Optional Feature:
- Macro: FP_ADDSUB_PIPE_STICKY_FLAGS_EN.
- When defined:
  - Adds input flags_clr (1 bit) and output flags (5 bits, status[5:1]).
  - flags ORs in status[5:1] of every fired output.
  - flags_clr=1 clears flags; a same-cycle fire's bits still set (set wins).
  - Reset clears flags.
- When undefined: ports absent, no registers.

Decomposition:
- Package fp_addsub_pkg:
  - typedef fp_op_e {FP_ADD=0, FP_SUB=1}.
  - Rounding-mode constants RND_RNE/RZ/RUP/RDN/RNA.
  - Status bit index constants STAT_ZERO..STAT_INEXACT.
  - Canonical single-precision QNaN constant 32'h7FC00000.
- One sub-module, fp_pipe_stage: a parametrised-width elastic register with val/ready logic, instantiated NSTAGES-1 times via generate.
- Stage 0 stays inline.

Test Plan:
- Basic add: NSTAGES=2, out_rdy=1, in0=0x3F800000, in1=0x40000000, add -> out=0x40400000 exactly 2 cycles later, status=0x00.
- Subtract to zero: in0=in1=0x3F800000, op=1 -> out=0x00000000, status=0x01. Then +inf - +inf (0x7F800000 both) -> out=0x7FC00000, status bit2 set.
- Backpressure: stream 6 back-to-back ops, out_rdy=0 for cycles 3-7 -> in_rdy falls once NSTAGES ops are held. All 6 results appear in order with correct values, none lost or duplicated.
- Bubble collapse: one op, gap, one op, out_rdy=0 until both are inside -> pipe holds both with no bubble, then emits them on consecutive cycles.
- Reset mid-operation: assert reset with 2 ops in flight -> out_val=0 and out=0 asynchronously. After release, in_rdy=1 and no stale results emerge.
- Sticky flags (macro on): 1.0 + 2^-30 (inexact) then flags_clr in the same cycle as a new inexact fire -> flags[4] (inexact) remains 1. A clr alone -> flags=0.
